// File: rtl/delay_pkg.sv
// delay_pkg: channel state encoding and clock-to-unit divider helper shared by the delay timer
package delay_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;
  function automatic int calc_div(input int clk_hz, input int unit_hz);
    return clk_hz / unit_hz;
  endfunction
endpackage

// File: rtl/delay_channel.sv
// delay_channel: one delay channel with unit prescaler, one-shot/periodic modes and long-start protection
module delay_channel
  import delay_pkg::*;
#(
  parameter int CNT_W = 12,
  parameter int DIV   = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] time_in,
  input  logic             start,
  input  logic             abort,
  input  logic             rpt,
  output logic             ready,
  output logic             busy,
  output logic             done
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  state_t state, state_nx;
  logic [CW-1:0] cyc;
  logic [CNT_W-1:0] unit, t_lat;
  logic cyc_end, term, z_done;
  assign cyc_end = cyc == CW'(DIV - 1);
  assign term = (state == RUN) && cyc_end && (unit == t_lat - CNT_W'(1));
  assign busy = state == RUN;
  assign ready = (state == IDLE) && !start;
  // abort beats a same-cycle completion; zero-length delays report one cycle after start
  assign done = (term && !abort) || z_done;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? ((t_lat != '0) ? RUN : HOLD) : IDLE;
      RUN:  state_nx = abort ? IDLE : !term ? RUN : (rpt && start) ? RUN : start ? HOLD : IDLE;
      HOLD: state_nx = start ? HOLD : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cyc    <= '0;
      unit   <= '0;
      t_lat  <= '0;
      z_done <= 1'b0;
    end else begin
      state  <= state_nx;
      z_done <= (state == IDLE) && start && (t_lat == '0);
      t_lat  <= (state == IDLE) ? time_in : t_lat;
      cyc    <= (state == RUN && state_nx == RUN && !cyc_end) ? cyc + CW'(1) : '0;
      unit   <= (state == RUN && state_nx == RUN && !term) ? unit + CNT_W'(cyc_end) : '0;
    end
  end
endmodule

// File: rtl/delay_timer.sv
// delay_timer: N_CH independent delay channels timed in units of CLK_HZ/UNIT_HZ clock cycles
module delay_timer
  import delay_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int CNT_W   = 12,
  parameter int CLK_HZ  = 100_000_000,
  parameter int UNIT_HZ = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*CNT_W-1:0] delay_time,
  input  logic [N_CH-1:0]       delay_start,
  input  logic [N_CH-1:0]       delay_abort,
  input  logic [N_CH-1:0]       delay_repeat,
  output logic [N_CH-1:0]       delay_ready,
  output logic [N_CH-1:0]       delay_busy,
  output logic [N_CH-1:0]       delay_done
);
  localparam int DIV = calc_div(CLK_HZ, UNIT_HZ);
  if ((CLK_HZ % UNIT_HZ) != 0 || DIV < 2) begin : g_bad_div
    $error("delay_timer: CLK_HZ must be a multiple of UNIT_HZ with DIV >= 2");
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    delay_channel #(.CNT_W(CNT_W), .DIV(DIV)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .time_in (delay_time[i*CNT_W +: CNT_W]),
      .start   (delay_start[i]),
      .abort   (delay_abort[i]),
      .rpt     (delay_repeat[i]),
      .ready   (delay_ready[i]),
      .busy    (delay_busy[i]),
      .done    (delay_done[i])
    );
  end
endmodule

// File: tb/tb_delay_timer.sv
// tb_delay_timer: directed stimulus with a done-pulse scoreboard keyed by expected cycle stamp
module tb_delay_timer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] delay_time;
  logic [1:0] delay_start, delay_abort, delay_repeat;
  logic [1:0] delay_ready, delay_busy, delay_done;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int exp_q[2][$];

  delay_timer #(.N_CH(2), .CNT_W(4), .CLK_HZ(1000), .UNIT_HZ(100)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .delay_time   (delay_time),
    .delay_start  (delay_start),
    .delay_abort  (delay_abort),
    .delay_repeat (delay_repeat),
    .delay_ready  (delay_ready),
    .delay_busy   (delay_busy),
    .delay_done   (delay_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Every done pulse must match the oldest expected stamp for its channel
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (delay_done[c]) begin
        n_tests++;
        if (exp_q[c].size() == 0) begin
          n_fail++;
          $display("FAIL done_unexpected ch%0d: pulse at cycle %0d, none expected", c, cyc);
        end else begin
          int e;
          e = exp_q[c].pop_front();
          if (e != cyc) begin
            n_fail++;
            $display("FAIL done_time ch%0d: pulse at cycle %0d expected %0d", c, cyc, e);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    delay_time = '0;
    delay_start = '0;
    delay_abort = '0;
    delay_repeat = '0;
    tick(3);
    chk("rst_busy", delay_busy, 0);
    chk("rst_done", delay_done, 0);
    chk("rst_ready", delay_ready, 3);
    delay_start = 2'b01;
    #1;
    chk("rst_ready_start", delay_ready, 2);
    delay_start = '0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    // one-shot T=3
    delay_time = 8'h03;
    tick(1);
    delay_start = 2'b01;
    exp_q[0].push_back(cyc + 30);
    tick(1);
    delay_start = '0;
    chk("oneshot_busy_first", delay_busy, 1);
    tick(29);
    chk("oneshot_busy_last", delay_busy, 1);
    tick(1);
    chk("oneshot_busy_end", delay_busy, 0);
    chk("oneshot_ready", delay_ready, 3);
    // zero-length delay with long start
    delay_time = 8'h00;
    tick(1);
    delay_start = 2'b01;
    exp_q[0].push_back(cyc + 1);
    tick(3);
    chk("zero_ready_held", delay_ready, 2);
    chk("zero_busy", delay_busy, 0);
    tick(2);
    delay_start = '0;
    tick(1);
    chk("zero_ready_back", delay_ready, 3);
    // periodic T=2, start dropped mid-period
    delay_time = 8'h02;
    delay_repeat = 2'b01;
    tick(1);
    delay_start = 2'b01;
    exp_q[0].push_back(cyc + 20);
    exp_q[0].push_back(cyc + 40);
    exp_q[0].push_back(cyc + 60);
    tick(45);
    delay_start = '0;
    chk("repeat_busy", delay_busy, 1);
    tick(16);
    chk("repeat_stopped", delay_busy, 0);
    delay_repeat = '0;
    // abort on the completion cycle
    delay_time = 8'h05;
    tick(1);
    delay_start = 2'b01;
    tick(1);
    delay_start = '0;
    tick(49);
    chk("abort_busy_pre", delay_busy, 1);
    delay_abort = 2'b01;
    tick(1);
    delay_abort = '0;
    chk("abort_busy", delay_busy, 0);
    chk("abort_ready", delay_ready, 3);
    // both channels, delay_time changed while running
    delay_time = 8'hF1;
    tick(1);
    delay_start = 2'b11;
    exp_q[0].push_back(cyc + 10);
    exp_q[1].push_back(cyc + 150);
    tick(1);
    delay_start = '0;
    delay_time = 8'h27;
    tick(5);
    chk("dual_busy", delay_busy, 3);
    tick(10);
    chk("dual_ch1_only", delay_busy, 2);
    tick(140);
    chk("dual_done_busy", delay_busy, 0);
    // reset in the middle of a run
    delay_time = 8'h04;
    tick(1);
    delay_start = 2'b01;
    tick(1);
    delay_start = '0;
    tick(16);
    chk("midrst_busy_pre", delay_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", delay_busy, 0);
    tick(2);
    rst_n = 1'b1;
    tick(50);
    chk("midrst_after_busy", delay_busy, 0);
    chk("midrst_after_ready", delay_ready, 3);
    for (int c = 0; c < 2; c++) chk($sformatf("missing_done_ch%0d", c), exp_q[c].size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
